// File: rtl/mc_sequencer_pkg.sv
// rtl/mc_sequencer_pkg.sv - shared state, PC-select encodings and defaults for mc_sequencer
package mc_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_ERR    = 3'd7
    } state_t;

    localparam logic [1:0] PC_MUX_SEL_NEWPC  = 2'b00;
    localparam logic [1:0] PC_MUX_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_MUX_SEL_JUMP   = 2'b10;
    localparam logic [1:0] PC_MUX_SEL_JR     = 2'b11;

    localparam int DEFAULT_TIMEOUT = 16;

    // A branch that was not taken in EXEC falls back to the sequential PC.
    function automatic logic [1:0] resolve_pc_src(input logic [1:0] pc_sel, input logic zero_q);
        return (pc_sel == PC_MUX_SEL_BRANCH && !zero_q) ? PC_MUX_SEL_NEWPC : pc_sel;
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// rtl/mc_wait_timer.sv - clearable wait-cycle up-counter with terminal flag
module mc_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic done
);

    localparam int W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && !done) begin
            count <= count + W'(1);
        end
    end

    assign done = (count == W'(LIMIT));

endmodule

// File: rtl/mc_sequencer.sv
// rtl/mc_sequencer.sv - multi-cycle fetch/decode/exec/mem/wb sequencer driving datapath enables
module mc_sequencer
    import mc_sequencer_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic             RegWrite,
    input  logic [1:0]       PC_sel,
    input  logic             Zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             reg_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             err
);

    state_t           cur;
    state_t           nxt;
    logic             zero_q;
    logic [CNT_W-1:0] retired_q;
    logic             wait_clr;
    logic             wait_inc;
    logic             wait_done;

    mc_wait_timer #(.LIMIT(TIMEOUT)) u_wait (
        .clk  (clk),
        .rst  (rst),
        .clr  (wait_clr),
        .inc  (wait_inc),
        .done (wait_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cur       <= ST_IDLE;
            zero_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            cur <= nxt;
            if (cur == ST_EXEC) begin
                zero_q <= Zero;
            end
            if (cur == ST_WB) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        nxt      = cur;
        wait_clr = 1'b0;
        wait_inc = 1'b0;
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        reg_we   = 1'b0;
        pc_we    = 1'b0;
        pc_src   = PC_MUX_SEL_NEWPC;
        case (cur)
            ST_IDLE: begin
                if (run) begin
                    nxt      = ST_FETCH;
                    wait_clr = 1'b1;
                end
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                // A ready arriving on the terminal count still completes the fetch.
                if (imem_ready) begin
                    ir_we = 1'b1;
                    nxt   = ST_DECODE;
                end else if (wait_done) begin
                    nxt = ST_ERR;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            ST_DECODE: nxt = ST_EXEC;
            ST_EXEC: begin
                if (MemRead && MemWrite) begin
                    nxt = ST_ERR;
                end else if (MemRead || MemWrite) begin
                    nxt      = ST_MEM;
                    wait_clr = 1'b1;
                end else begin
                    nxt = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = MemWrite;
                if (dmem_ready) begin
                    nxt = ST_WB;
                end else if (wait_done) begin
                    nxt = ST_ERR;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            ST_WB: begin
                reg_we = RegWrite;
                pc_we  = 1'b1;
                pc_src = resolve_pc_src(PC_sel, zero_q);
                if (run) begin
                    nxt      = ST_FETCH;
                    wait_clr = 1'b1;
                end else begin
                    nxt = ST_IDLE;
                end
            end
            ST_ERR:  nxt = ST_ERR;
            default: nxt = ST_ERR;
        endcase
    end

    assign state   = cur;
    assign retired = retired_q;
    assign err     = (cur == ST_ERR);

endmodule

// File: tb/tb_mc_sequencer.sv
// tb/tb_mc_sequencer.sv - randomized self-checking bench for mc_sequencer
module tb_mc_sequencer;

    localparam int TO = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run = 1'b0;
    logic          MemRead = 1'b0;
    logic          MemWrite = 1'b0;
    logic          RegWrite = 1'b0;
    logic [1:0]    PC_sel = 2'b00;
    logic          Zero = 1'b0;
    logic          imem_ready = 1'b0;
    logic          dmem_ready = 1'b0;
    logic          imem_req;
    logic          ir_we;
    logic          dmem_req;
    logic          dmem_we;
    logic          reg_we;
    logic          pc_we;
    logic [1:0]    pc_src;
    logic [2:0]    state;
    logic [CW-1:0] retired;
    logic          err;

    int errors = 0;
    int checks = 0;
    int model_retired = 0;

    mc_sequencer #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .PC_sel     (PC_sel),
        .Zero       (Zero),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .ir_we      (ir_we),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .reg_we     (reg_we),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .state      (state),
        .retired    (retired),
        .err        (err)
    );

    always #5 clk = ~clk;

    wire [11:0] obs = {state, imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, pc_src, err};

    function automatic logic [11:0] ev(input int st, input bit ireq, input bit iwe, input bit dreq,
                                       input bit dwe, input bit rwe, input bit pwe,
                                       input logic [1:0] src, input bit e);
        logic [2:0] s;
        s = st[2:0];
        return {s, ireq, iwe, dreq, dwe, rwe, pwe, src, e};
    endfunction

    // One instruction expanded into its phase list; each phase is one cycle.
    task automatic do_instr(input bit mr, input bit mw, input bit rw, input logic [1:0] pcs,
                            input bit z_exec, input bit z_wb, input int iw, input int dw,
                            input bit run_next, input string tag);
        int         ph[$];
        bit         rdy[$];
        logic [11:0] exp_v;
        logic [1:0] exp_src;
        for (int j = 0; j <= iw; j++) begin ph.push_back(1); rdy.push_back(j == iw); end
        ph.push_back(2); rdy.push_back(0);
        ph.push_back(3); rdy.push_back(0);
        if (mr || mw) begin
            for (int j = 0; j <= dw; j++) begin ph.push_back(4); rdy.push_back(j == dw); end
        end
        ph.push_back(5); rdy.push_back(0);
        exp_src = (pcs == 2'b01 && !z_exec) ? 2'b00 : pcs;
        MemRead = mr; MemWrite = mw; RegWrite = rw; PC_sel = pcs;
        for (int k = 0; k < ph.size(); k++) begin
            imem_ready = 1'($urandom); dmem_ready = 1'($urandom); Zero = 1'($urandom);
            case (ph[k])
                1: begin imem_ready = rdy[k]; exp_v = ev(1, 1, rdy[k], 0, 0, 0, 0, 2'b00, 0); end
                2: exp_v = ev(2, 0, 0, 0, 0, 0, 0, 2'b00, 0);
                3: begin Zero = z_exec; run = run_next; exp_v = ev(3, 0, 0, 0, 0, 0, 0, 2'b00, 0); end
                4: begin dmem_ready = rdy[k]; exp_v = ev(4, 0, 0, 1, mw, 0, 0, 2'b00, 0); end
                default: begin Zero = z_wb; exp_v = ev(5, 0, 0, 0, 0, rw, 1, exp_src, 0); end
            endcase
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL %s phase=%0d cyc=%0d got=%h want=%h", tag, ph[k], k, obs, exp_v);
            end
            @(posedge clk); #1;
        end
        model_retired = (model_retired + 1) % (1 << CW);
        checks++;
        if (retired !== CW'(model_retired)) begin
            errors++;
            $display("FAIL %s retired got=%0d want=%0d", tag, retired, model_retired);
        end
    endtask

    task automatic idle_to_run(input string tag);
        run = 1'b1; imem_ready = 1'($urandom); dmem_ready = 1'($urandom);
        @(negedge clk);
        checks++;
        if (obs !== ev(0, 0, 0, 0, 0, 0, 0, 2'b00, 0)) begin
            errors++;
            $display("FAIL %s idle got=%h want=%h", tag, obs, ev(0, 0, 0, 0, 0, 0, 0, 2'b00, 0));
        end
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b1; run = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; run = 1'b0;
        model_retired = 0;
        @(negedge clk);
        checks++;
        if (obs !== ev(0, 0, 0, 0, 0, 0, 0, 2'b00, 0) || retired !== '0) begin
            errors++;
            $display("FAIL %s after reset got=%h retired=%0d want=000 retired=0", tag, obs, retired);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (obs !== ev(0, 0, 0, 0, 0, 0, 0, 2'b00, 0) || retired !== '0) begin
            errors++;
            $display("FAIL reset got=%h retired=%0d want=000 retired=0", obs, retired);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_add();
        idle_to_run("add");
        do_instr(0, 0, 1, 2'b00, 1'($urandom), 1'($urandom), 0, 0, 0, "add");
        idle_to_run("add_end");
    endtask

    task automatic test_store();
        do_instr(0, 1, 0, 2'b00, 0, 0, 0, 3, 1, "sw");
        do_instr(1, 0, 1, 2'b00, 0, 0, 2, 1, 1, "lw");
    endtask

    task automatic test_branch();
        do_instr(0, 0, 0, 2'b01, 1, 0, 0, 0, 1, "beq_taken");
        do_instr(0, 0, 0, 2'b01, 0, 1, 0, 0, 1, "beq_not");
        do_instr(0, 0, 0, 2'b10, 0, 1, 0, 0, 1, "jump");
        do_instr(0, 0, 1, 2'b11, 0, 0, 0, 0, 1, "jr");
    endtask

    task automatic test_ready_at_limit();
        do_instr(1, 0, 1, 2'b00, 0, 0, TO, TO, 1, "limit");
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 24; n++) begin
            bit mr, mw;
            mr = 1'($urandom); mw = mr ? 1'b0 : 1'($urandom);
            do_instr(mr, mw, 1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                     ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO) : $urandom_range(0, 2),
                     ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO) : $urandom_range(0, 2),
                     1, "rand");
        end
    endtask

    task automatic test_run_drop_in_mem();
        do_instr(0, 1, 1, 2'b00, 0, 0, 0, 2, 0, "run_drop");
        idle_to_run("run_drop_idle");
    endtask

    task automatic test_reset_mid_mem();
        MemRead = 1'b1; MemWrite = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (obs !== ev(4, 0, 0, 1, 0, 0, 0, 2'b00, 0)) begin
            errors++;
            $display("FAIL rst_mid_mem in_mem got=%h want=%h", obs, ev(4, 0, 0, 1, 0, 0, 0, 2'b00, 0));
        end
        @(posedge clk); #1;
        pulse_reset("rst_mid_mem");
    endtask

    task automatic test_timeout();
        logic [11:0] ferr;
        ferr = ev(7, 0, 0, 0, 0, 0, 0, 2'b00, 1);
        idle_to_run("to_fetch");
        imem_ready = 1'b0;
        for (int c = 0; c <= TO; c++) begin
            dmem_ready = 1'($urandom);
            @(negedge clk);
            checks++;
            if (obs !== ev(1, 1, 0, 0, 0, 0, 0, 2'b00, 0)) begin
                errors++;
                $display("FAIL to_fetch cyc=%0d got=%h want=%h", c, obs, ev(1, 1, 0, 0, 0, 0, 0, 2'b00, 0));
            end
            @(posedge clk); #1;
        end
        for (int c = 0; c < 3; c++) begin
            imem_ready = 1'($urandom); dmem_ready = 1'($urandom);
            @(negedge clk);
            checks++;
            if (obs !== ferr) begin
                errors++;
                $display("FAIL to_fetch_err cyc=%0d got=%h want=%h", c, obs, ferr);
            end
            @(posedge clk); #1;
        end
        pulse_reset("to_fetch");
    endtask

    task automatic test_mem_timeout();
        idle_to_run("to_mem");
        MemRead = 1'b0; MemWrite = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        imem_ready = 1'b0;
        repeat (TO + 1) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (obs !== ev(7, 0, 0, 0, 0, 0, 0, 2'b00, 1)) begin
            errors++;
            $display("FAIL to_mem got=%h want=%h", obs, ev(7, 0, 0, 0, 0, 0, 0, 2'b00, 1));
        end
        @(posedge clk); #1;
        pulse_reset("to_mem");
    endtask

    task automatic test_conflict();
        idle_to_run("conflict");
        MemRead = 1'b1; MemWrite = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (dmem_req !== 1'b0 || state !== ((c < 3) ? 3'(c + 1) : 3'd7)) begin
                errors++;
                $display("FAIL conflict cyc=%0d state=%0d dmem_req=%b want state=%0d dmem_req=0",
                         c, state, dmem_req, (c < 3) ? c + 1 : 7);
            end
            @(posedge clk); #1;
        end
        pulse_reset("conflict");
    endtask

    initial begin
        test_reset();
        test_add();
        test_store();
        test_branch();
        test_ready_at_limit();
        test_back_to_back();
        test_run_drop_in_mem();
        test_reset_mid_mem();
        test_timeout();
        test_mem_timeout();
        test_conflict();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
